// File: rtl/crg_hostif_regbank_if.sv
// Host-side register bus between the UART controller and the CRG register bank.
// Latency: the read data returns one cycle after addr_extout.
// Backpressure: none; writes and run are single-cycle strobes that are always accepted.
interface crg_hostif_regbank_if #(
    parameter int DIN_W  = 256,
    parameter int DOUT_W = 768,
    parameter int AW     = 8
);
    logic              extin_en;
    logic [AW-1:0]     addr_extin;
    logic [DIN_W-1:0]  extin_data;
    logic              run;
    logic [AW-1:0]     addr_extout;
    logic [DOUT_W-1:0] extout_data;

    // UART controller side
    modport master (
        output extin_en, addr_extin, extin_data, run, addr_extout,
        input  extout_data
    );

    // register bank side
    modport slave (
        input  extin_en, addr_extin, extin_data, run, addr_extout,
        output extout_data
    );
endinterface

// File: rtl/crg_hostif_regbank.sv
// Register bank: collects operand words, launches the CRG core, captures results, serves readback.
// Latency: run to core_start 1 cycle; addr_extout to extout_data 1 cycle.
// Backpressure: none; writes/run while busy are dropped and flagged in sticky error bits.
module crg_hostif_regbank #(
    parameter int          DIN_W       = 256,
    parameter int          NUM_IN      = 4,
    parameter int          DOUT_W      = 768,
    parameter int          NUM_OUT     = 2,
    parameter int          AW          = 8,
    parameter int          TIMEOUT_CYC = 1048576,
    parameter logic [11:0] ID          = 12'h58F
) (
    input  logic                      clk,
    input  logic                      rst_n,
    crg_hostif_regbank_if.slave       host,
    output logic                      core_start,
    output logic [NUM_IN*DIN_W-1:0]   core_args,
    input  logic                      core_done,
    input  logic [NUM_OUT*DOUT_W-1:0] core_result,
    output logic                      busy,
    output logic [3:0]                led
);
    // top address reads status, the one below it clears errors/done
    localparam logic [AW-1:0] STAT_ADDR = '1;
    localparam logic [AW-1:0] CLR_ADDR  = STAT_ADDR - 1'b1;
    localparam int            TW        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST   = (TIMEOUT_CYC == 0) ? '0 : TW'(TIMEOUT_CYC - 1);
    localparam int            ZW        = DOUT_W - 12 - 32;

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t                         state;
    logic [NUM_IN-1:0][DIN_W-1:0]   in_reg;
    logic [NUM_OUT-1:0][DOUT_W-1:0] result_reg;
    logic                           done;
    logic                           err_addr;
    logic                           err_wr_busy;
    logic                           err_run_busy;
    logic                           err_timeout;
    logic [15:0]                    run_cnt;
    logic [TW-1:0]                  to_cnt;
    logic [25:0]                    hb_cnt;
    logic                           heartbeat;
    logic                           wr_operand;
    logic                           wr_clr;
    logic                           wr_bad;
    logic                           err_any;
    logic [DOUT_W-1:0]              status_word;
    logic [DOUT_W-1:0]              rd_data;

    assign wr_operand = host.extin_en && (32'(host.addr_extin) < NUM_IN);
    assign wr_clr     = host.extin_en && (host.addr_extin == CLR_ADDR);
    assign wr_bad     = host.extin_en && !wr_operand && !wr_clr;
    assign err_any    = err_addr | err_wr_busy | err_run_busy | err_timeout;
    assign core_args  = in_reg;
    assign led        = {err_any, done, busy, heartbeat};

    assign status_word = {ID, {ZW{1'b0}}, run_cnt, 10'b0,
                          err_timeout, err_run_busy, err_wr_busy, err_addr, done, busy};

    // operand registers only accept writes while the core is idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_reg <= '0;
        end else if (wr_operand && state == IDLE) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (host.addr_extin == AW'(i)) in_reg[i] <= host.extin_data;
            end
        end
    end

    // run/launch/wait FSM with registered core_start/busy, result capture and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            core_start   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_addr     <= 1'b0;
            err_wr_busy  <= 1'b0;
            err_run_busy <= 1'b0;
            err_timeout  <= 1'b0;
            run_cnt      <= '0;
            to_cnt       <= '0;
            result_reg   <= '0;
        end else begin
            core_start <= 1'b0;
            // clear first so that any event in the same cycle still sets its flag
            if (wr_clr) begin
                done         <= 1'b0;
                err_addr     <= 1'b0;
                err_wr_busy  <= 1'b0;
                err_run_busy <= 1'b0;
                err_timeout  <= 1'b0;
            end
            if (wr_bad) err_addr <= 1'b1;
            if (wr_operand && state != IDLE) err_wr_busy <= 1'b1;
            if (host.run && state != IDLE) err_run_busy <= 1'b1;
            case (state)
                IDLE: begin
                    if (host.run) begin
                        state      <= START;
                        done       <= 1'b0;
                        run_cnt    <= run_cnt + 16'd1;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                START: begin
                    state  <= WAIT;
                    to_cnt <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        result_reg <= core_result;
                        done       <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end else if (TIMEOUT_CYC != 0 && to_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // readback mux: results low, operands above them, status at the top address
    always_comb begin
        rd_data = '0;
        if (host.addr_extout == STAT_ADDR) begin
            rd_data = status_word;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (host.addr_extout == AW'(i)) rd_data = result_reg[i];
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (host.addr_extout == AW'(NUM_OUT + i)) rd_data = DOUT_W'(in_reg[i]);
            end
        end
    end

    // registered read data
    always_ff @(posedge clk) begin
        if (!rst_n) host.extout_data <= '0;
        else        host.extout_data <= rd_data;
    end

    // free-running heartbeat, toggles every 2^26 cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else begin
            hb_cnt <= hb_cnt + 26'd1;
            if (&hb_cnt) heartbeat <= ~heartbeat;
        end
    end
endmodule

// File: tb/tb_crg_hostif_regbank.sv
// Bench for crg_hostif_regbank: table-driven write/readback plus run/timeout/error/reset sequences.
// Latency: reads are compared one cycle after the address is driven, via an expectation queue.
// Backpressure: none; the bench drives single-cycle strobes.
module tb_crg_hostif_regbank;
    localparam int DIN_W   = 256;
    localparam int NUM_IN  = 4;
    localparam int DOUT_W  = 768;
    localparam int NUM_OUT = 2;
    localparam int AW      = 8;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      core_start;
    logic [NUM_IN*DIN_W-1:0]   core_args;
    logic                      core_done;
    logic [NUM_OUT*DOUT_W-1:0] core_result;
    logic                      busy;
    logic [3:0]                led;

    crg_hostif_regbank_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .AW(AW)) hif ();

    crg_hostif_regbank #(
        .DIN_W(DIN_W), .NUM_IN(NUM_IN), .DOUT_W(DOUT_W), .NUM_OUT(NUM_OUT),
        .AW(AW), .TIMEOUT_CYC(16), .ID(12'h58F)
    ) dut (
        .clk(clk), .rst_n(rst_n), .host(hif),
        .core_start(core_start), .core_args(core_args),
        .core_done(core_done), .core_result(core_result),
        .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [DOUT_W-1:0] exp;
    } exp_t;

    typedef struct {
        string             name;
        logic              we;
        logic [AW-1:0]     wa;
        logic [DIN_W-1:0]  wd;
        logic [AW-1:0]     ra;
        logic [DOUT_W-1:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vt[8];
    int   checks = 0;
    int   errors = 0;

    logic [DIN_W-1:0] d0, da5, d3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DOUT_W-1:0] act, input logic [DOUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h exp %h", name, act, exp);
        end
    endtask

    function automatic logic [DOUT_W-1:0] stat(input logic [15:0] rc, input logic [5:0] fl);
        logic [DOUT_W-1:0] s;
        s = '0;
        s[DOUT_W-1 -: 12] = 12'h58F;
        s[31:16] = rc;
        s[5:0] = fl;
        return s;
    endfunction

    task automatic wr(input logic [AW-1:0] a, input logic [DIN_W-1:0] d);
        hif.extin_en   = 1'b1;
        hif.addr_extin = a;
        hif.extin_data = d;
        tick();
        hif.extin_en   = 1'b0;
    endtask

    task automatic pulse_run();
        hif.run = 1'b1;
        tick();
        hif.run = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DOUT_W-1:0] exp);
        exp_t e;
        hif.addr_extout = a;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
        tick();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            chk(e.name, hif.extout_data, e.exp);
        end
    endtask

    initial begin
        int busy_cnt;
        int start_cnt;

        rst_n           = 1'b0;
        hif.extin_en    = 1'b0;
        hif.addr_extin  = '0;
        hif.extin_data  = '0;
        hif.run         = 1'b0;
        hif.addr_extout = 8'hFF;
        core_done       = 1'b0;
        core_result     = '0;
        repeat (3) tick();
        chk("rst_extout", hif.extout_data, '0);
        chk("rst_busy", DOUT_W'(busy), '0);
        chk("rst_core_start", DOUT_W'(core_start), '0);
        chk("rst_led", DOUT_W'(led), '0);
        rst_n = 1'b1;
        rd_chk("rst_status", 8'hFF, stat(16'd0, 6'b000000));

        // table-driven writes and readbacks
        d0  = {8{32'h0BADF00D}};
        da5 = {32{8'hA5}};
        d3  = {4{64'h0123456789ABCDEF}};
        vt[0] = '{"wr0_rd2", 1'b1, 8'd0, d0,      8'd2,  DOUT_W'(d0)};
        vt[1] = '{"wr1_rd3", 1'b1, 8'd1, da5,     8'd3,  DOUT_W'(da5)};
        vt[2] = '{"wr3_rd5", 1'b1, 8'd3, d3,      8'd5,  DOUT_W'(d3)};
        vt[3] = '{"rd6_nil", 1'b0, 8'd0, '0,      8'd6,  '0};
        vt[4] = '{"rd_res0", 1'b0, 8'd0, '0,      8'd0,  '0};
        vt[5] = '{"rd_res1", 1'b0, 8'd0, '0,      8'd1,  '0};
        vt[6] = '{"wr2_rd4", 1'b1, 8'd2, 256'h42, 8'd4,  DOUT_W'(256'h42)};
        vt[7] = '{"rd_stat", 1'b0, 8'd0, '0,      8'hFF, stat(16'd0, 6'b000000)};
        for (int i = 0; i < 8; i++) begin
            if (vt[i].we) wr(vt[i].wa, vt[i].wd);
            rd_chk(vt[i].name, vt[i].ra, vt[i].exp);
        end
        chk("core_args_w1", DOUT_W'(core_args[511:256]), DOUT_W'(da5));

        // normal run: done 10 cycles after core_start
        core_result = '0;
        core_result[DOUT_W-1:0] = DOUT_W'(16'h0055);
        core_result[2*DOUT_W-1:DOUT_W] = DOUT_W'(16'h1234);
        pulse_run();
        chk("start_after_run", DOUT_W'(core_start), DOUT_W'(1'b1));
        busy_cnt  = 0;
        start_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            if (busy) busy_cnt++;
            if (core_start) start_cnt++;
            core_done = (k == 10);
            tick();
        end
        core_done = 1'b0;
        chk("busy_cycles", DOUT_W'(busy_cnt), DOUT_W'(11));
        chk("start_pulses", DOUT_W'(start_cnt), DOUT_W'(1));
        rd_chk("res1_1234", 8'd1, DOUT_W'(16'h1234));
        rd_chk("res0_55", 8'd0, DOUT_W'(16'h0055));
        rd_chk("stat_done", 8'hFF, stat(16'd1, 6'b000010));
        chk("led_done", DOUT_W'(led), DOUT_W'(4'b0100));

        // timeout: 16 WAIT cycles then back to IDLE
        core_result = '1;
        pulse_run();
        repeat (16) tick();
        chk("to_busy_last", DOUT_W'(busy), DOUT_W'(1'b1));
        tick();
        chk("to_busy_idle", DOUT_W'(busy), '0);
        rd_chk("stat_timeout", 8'hFF, stat(16'd2, 6'b100000));
        rd_chk("to_res1_kept", 8'd1, DOUT_W'(16'h1234));
        chk("led_err", DOUT_W'(led), DOUT_W'(4'b1000));
        wr(8'hFE, '1);
        rd_chk("stat_clr", 8'hFF, stat(16'd2, 6'b000000));

        // errors while busy
        core_result = '0;
        core_result[DOUT_W-1:0] = DOUT_W'(8'hAA);
        core_result[2*DOUT_W-1:DOUT_W] = DOUT_W'(8'hBB);
        pulse_run();
        tick();
        wr(8'd0, 256'hDEAD);
        pulse_run();
        wr(8'd9, 256'h1);
        rd_chk("stat_busy_errs", 8'hFF, stat(16'd3, 6'b011101));
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rd_chk("in0_kept", 8'd2, DOUT_W'(d0));
        rd_chk("stat_errs_done", 8'hFF, stat(16'd3, 6'b011110));
        rd_chk("res0_aa", 8'd0, DOUT_W'(8'hAA));
        wr(8'hFE, '0);
        rd_chk("stat_clr2", 8'hFF, stat(16'd3, 6'b000000));

        // same-cycle write and run, then reset during WAIT
        hif.extin_en   = 1'b1;
        hif.addr_extin = 8'd0;
        hif.extin_data = 256'h77;
        hif.run        = 1'b1;
        tick();
        hif.extin_en   = 1'b0;
        hif.run        = 1'b0;
        chk("same_cyc_start", DOUT_W'(core_start), DOUT_W'(1'b1));
        chk("same_cyc_args", DOUT_W'(core_args[255:0]), DOUT_W'(256'h77));
        tick();
        tick();
        chk("wait_busy", DOUT_W'(busy), DOUT_W'(1'b1));
        rst_n = 1'b0;
        tick();
        chk("rst_abort_busy", DOUT_W'(busy), '0);
        rst_n = 1'b1;
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        rd_chk("stat_after_rst", 8'hFF, stat(16'd0, 6'b000000));
        rd_chk("in0_after_rst", 8'd2, '0);
        rd_chk("res0_after_rst", 8'd0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
